// File: rtl/dram_pkg.sv
// Shared types and defaults for the DRAM access controller and its refresh timer.
package dram_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      RD_WAIT = 3'd3,
      REFRESH = 3'd4
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh down-counter; raises refresh_pending on expiry until cleared.
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic refresh_pending
);

   localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

   logic [CW-1:0] r_timer;
   logic          r_pending;
   logic          w_expire;

   assign w_expire        = (r_timer == {CW{1'b0}});
   assign refresh_pending = r_pending;

   // Countdown with reload; a clear on REFRESH entry wins, and an expiry while pending is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer   <= RELOAD;
         r_pending <= 1'b0;
      end else begin
         r_timer <= w_expire ? RELOAD : (r_timer - CW'(1));
         if (clear) begin
            r_pending <= 1'b0;
         end else if (w_expire) begin
            r_pending <= 1'b1;
         end else begin
            r_pending <= r_pending;
         end
      end
   end

endmodule

// File: rtl/dram_access_ctrl.sv
// Request/refresh sequencer for one DRAM array port with registered mem_*/rsp_* outputs.
// Optional access statistics: define DRAM_ACCESS_CTRL_STATS_EN.
module dram_access_ctrl
   import dram_pkg::*;
#(
   parameter int DATA_W           = DATA_W_DEF,
   parameter int ADDR_W           = ADDR_W_DEF,
   parameter int REFRESH_INTERVAL = 64,
   parameter int REFRESH_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_we,
   output logic              mem_enable,
   output logic              mem_refresh_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              refresh_busy
`ifdef DRAM_ACCESS_CTRL_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   output logic [15:0]       ref_count
`endif
);

   localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_ref_cnt, w_ref_cnt_nxt;
   logic              r_mem_we, w_mem_we_nxt;
   logic              r_mem_enable, w_mem_enable_nxt;
   logic              r_refresh_en, w_refresh_en_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic              w_pending;
   logic              w_clear;
   logic              w_rd_acc;
   logic              w_wr_acc;

   dram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_timer (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (w_clear),
      .refresh_pending (w_pending)
   );

   assign req_ready      = (r_state == IDLE) & ~w_pending;
   assign mem_we         = r_mem_we;
   assign mem_enable     = r_mem_enable;
   assign mem_refresh_en = r_refresh_en;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_rdata      = r_rsp_rdata;
   assign refresh_busy   = r_busy;

   // Next-state and next-output decode; strobes default low, address/data/rdata hold.
   always_comb begin
      w_state_nxt      = r_state;
      w_ref_cnt_nxt    = r_ref_cnt;
      w_mem_we_nxt     = 1'b0;
      w_mem_enable_nxt = 1'b0;
      w_refresh_en_nxt = 1'b0;
      w_busy_nxt       = 1'b0;
      w_rsp_valid_nxt  = 1'b0;
      w_rsp_rdata_nxt  = r_rsp_rdata;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_clear          = 1'b0;
      w_rd_acc         = 1'b0;
      w_wr_acc         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pending) begin
               w_state_nxt      = REFRESH;
               w_ref_cnt_nxt    = {CNT_W{1'b0}};
               w_refresh_en_nxt = 1'b1;
               w_busy_nxt       = 1'b1;
               w_clear          = 1'b1;
            end else if (req_valid) begin
               w_mem_addr_nxt  = req_addr;
               w_mem_wdata_nxt = req_wdata;
               if (req_we) begin
                  w_mem_we_nxt = 1'b1;
                  w_wr_acc     = 1'b1;
                  w_state_nxt  = WRITE;
               end else begin
                  w_mem_enable_nxt = 1'b1;
                  w_rd_acc         = 1'b1;
                  w_state_nxt      = READ;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WRITE:   w_state_nxt = IDLE;
         READ:    w_state_nxt = RD_WAIT;
         RD_WAIT: begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = mem_rdata;
            w_state_nxt     = IDLE;
         end
         REFRESH: begin
            if (r_ref_cnt == REF_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_ref_cnt_nxt    = r_ref_cnt + CNT_W'(1);
               w_refresh_en_nxt = 1'b1;
               w_busy_nxt       = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_ref_cnt    <= {CNT_W{1'b0}};
         r_mem_we     <= 1'b0;
         r_mem_enable <= 1'b0;
         r_refresh_en <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= {DATA_W{1'b0}};
         r_mem_addr   <= {ADDR_W{1'b0}};
         r_mem_wdata  <= {DATA_W{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_ref_cnt    <= w_ref_cnt_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_enable <= w_mem_enable_nxt;
         r_refresh_en <= w_refresh_en_nxt;
         r_busy       <= w_busy_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_rdata  <= w_rsp_rdata_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
      end
   end

`ifdef DRAM_ACCESS_CTRL_STATS_EN
   logic [15:0] r_rd_count, r_wr_count, r_ref_count;

   assign rd_count  = r_rd_count;
   assign wr_count  = r_wr_count;
   assign ref_count = r_ref_count;

   // Saturating access/refresh counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_count  <= 16'd0;
         r_wr_count  <= 16'd0;
         r_ref_count <= 16'd0;
      end else begin
         r_rd_count  <= w_rd_acc ? sat_inc16(r_rd_count)  : r_rd_count;
         r_wr_count  <= w_wr_acc ? sat_inc16(r_wr_count)  : r_wr_count;
         r_ref_count <= w_clear  ? sat_inc16(r_ref_count) : r_ref_count;
      end
   end
`else
   logic w_unused_stats;
   assign w_unused_stats = w_rd_acc ^ w_wr_acc;
`endif

endmodule
